// File: rtl/gray_pkg.sv
// Shared helpers for the Gray counter: wide count carrier plus binary/Gray conversions.
package gray_pkg;

    localparam int CNT_W_MAX = 64;

    // Widest supported count; users cast in and compare at full width.
    typedef logic [CNT_W_MAX-1:0] cnt_t;

    function automatic cnt_t bin2gray(input cnt_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic cnt_t gray2bin(input cnt_t g);
        cnt_t b;
        b = g;
        for (int i = 1; i < CNT_W_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_next.sv
// Combinational next binary count and wrap detection for one counting step.
// Honours GRAY_MOD_EN: when defined the count wraps at mod_max instead of all-ones.
module gray_next #(
    parameter int CBITS = 14
) (
    input  logic [CBITS-1:0] bin,
    input  logic             dir,
    input  logic             en,
`ifdef GRAY_MOD_EN
    input  logic [CBITS-1:0] mod_max,
`endif
    output logic [CBITS-1:0] nxt,
    output logic             wrap
);

    localparam logic [CBITS-1:0] ONE = CBITS'(1);

    always_comb begin
        nxt  = bin;
        wrap = 1'b0;
        if (en) begin
            if (!dir) begin
`ifdef GRAY_MOD_EN
                // Anything at or above the terminal value folds back to zero.
                if (bin >= mod_max) begin
                    nxt  = '0;
                    wrap = 1'b1;
                end else begin
                    nxt = bin + ONE;
                end
`else
                nxt  = bin + ONE;
                wrap = &bin;
`endif
            end else begin
                wrap = (bin == '0);
`ifdef GRAY_MOD_EN
                nxt = wrap ? mod_max : bin - ONE;
`else
                nxt = bin - ONE;
`endif
            end
        end
    end

endmodule

// File: rtl/gray_counter_gen.sv
// Up/down Gray counter with clear/load priority, registered binary and Gray views.
// Optional modulus via GRAY_MOD_EN (adds mod_max port).
module gray_counter_gen
    import gray_pkg::*;
#(
    parameter int               CBITS = 14,
    parameter logic [CBITS-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [CBITS-1:0] load_val,
`ifdef GRAY_MOD_EN
    input  logic [CBITS-1:0] mod_max,
`endif
    output logic [CBITS-1:0] bin_cnt,
    output logic [CBITS-1:0] gray_cnt,
    output logic             wrap,
    output logic             zero
);

    localparam cnt_t             INIT_GRAY_W = bin2gray(cnt_t'(INIT));
    localparam logic [CBITS-1:0] INIT_GRAY   = INIT_GRAY_W[CBITS-1:0];

    logic [CBITS-1:0] step_nxt;
    logic             step_wrap;
    logic [CBITS-1:0] next_bin;
    logic             next_wrap;

    gray_next #(.CBITS(CBITS)) u_next (
        .bin     (bin_cnt),
        .dir     (dir),
        .en      (en),
`ifdef GRAY_MOD_EN
        .mod_max (mod_max),
`endif
        .nxt     (step_nxt),
        .wrap    (step_wrap)
    );

    always_comb begin
        next_bin  = step_nxt;
        next_wrap = step_wrap;
        if (clr) begin
            next_bin  = INIT;
            next_wrap = 1'b0;
        end else if (load) begin
            next_bin  = load_val;
            next_wrap = 1'b0;
        end
    end

    // Gray and zero derive from the next binary value so all views update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt  <= INIT;
            gray_cnt <= INIT_GRAY;
            wrap     <= 1'b0;
            zero     <= (INIT == '0);
        end else begin
            bin_cnt  <= next_bin;
            gray_cnt <= next_bin ^ (next_bin >> 1);
            wrap     <= next_wrap;
            zero     <= (next_bin == '0);
        end
    end

`ifndef SYNTHESIS
    always_comb begin
        a_gray_match: assert (cnt_t'(gray_cnt) == bin2gray(cnt_t'(bin_cnt)));
    end
`ifndef GRAY_MOD_EN
    a_one_bit_step: assert property (@(posedge clk) disable iff (!rst_n)
        (en && !clr && !load) |=> ($countones(gray_cnt ^ $past(gray_cnt)) == 1));
`endif
`endif

endmodule

// File: tb/tb_gray_counter_gen.sv
// Scoreboard bench for gray_counter_gen at CBITS=4, INIT=0 (GRAY_MOD_EN selects modulus tests).
module tb_gray_counter_gen;
    import gray_pkg::*;

    localparam int CBITS = 4;
    localparam logic [CBITS-1:0] INIT = '0;
`ifdef GRAY_MOD_EN
    localparam logic [CBITS-1:0] MOD = 4'd9;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             dir;
    logic             clr;
    logic             load;
    logic [CBITS-1:0] load_val;
`ifdef GRAY_MOD_EN
    logic [CBITS-1:0] mod_max;
`endif
    logic [CBITS-1:0] bin_cnt;
    logic [CBITS-1:0] gray_cnt;
    logic             wrap;
    logic             zero;

    gray_counter_gen #(.CBITS(CBITS), .INIT(INIT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef GRAY_MOD_EN
        .mod_max  (mod_max),
`endif
        .bin_cnt  (bin_cnt),
        .gray_cnt (gray_cnt),
        .wrap     (wrap),
        .zero     (zero)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*CBITS+1:0] exp_q[$];
    logic [CBITS-1:0]   m_cnt;
    logic               m_wrap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference step: clr > load > en > hold
    task automatic model_step(input logic s_en, input logic s_dir, input logic s_clr,
                              input logic s_load, input logic [CBITS-1:0] s_lv);
        if (s_clr) begin
            m_cnt = INIT; m_wrap = 1'b0;
        end else if (s_load) begin
            m_cnt = s_lv; m_wrap = 1'b0;
        end else if (s_en) begin
            if (!s_dir) begin
`ifdef GRAY_MOD_EN
                m_wrap = (m_cnt >= MOD);
                m_cnt  = m_wrap ? 4'd0 : m_cnt + 4'd1;
`else
                m_wrap = (m_cnt == 4'hF);
                m_cnt  = m_cnt + 4'd1;
`endif
            end else begin
                m_wrap = (m_cnt == 4'd0);
`ifdef GRAY_MOD_EN
                m_cnt  = m_wrap ? MOD : m_cnt - 4'd1;
`else
                m_cnt  = m_cnt - 4'd1;
`endif
            end
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    // driver: drive one command, push expectation, compare after the edge
    task automatic drive_step(input logic s_en, input logic s_dir, input logic s_clr,
                              input logic s_load, input logic [CBITS-1:0] s_lv,
                              output logic [2*CBITS+1:0] got);
        logic [2*CBITS+1:0] exp;
        cnt_t gb;
        @(negedge clk);
        en = s_en; dir = s_dir; clr = s_clr; load = s_load; load_val = s_lv;
        model_step(s_en, s_dir, s_clr, s_load, s_lv);
        exp_q.push_back({m_cnt, m_cnt ^ (m_cnt >> 1), m_wrap, m_cnt == 4'd0});
        @(posedge clk);
        #1;
        got = {bin_cnt, gray_cnt, wrap, zero};
        exp = exp_q.pop_front();
        check("step", 64'(got), 64'(exp));
        gb = gray2bin(cnt_t'(gray_cnt));
        check("gray2bin", gb, cnt_t'(bin_cnt));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bin"},  64'(bin_cnt),  64'(INIT));
        check({tag, "_gray"}, 64'(gray_cnt), 64'(INIT ^ (INIT >> 1)));
        check({tag, "_wrap"}, 64'(wrap),     64'd0);
        check({tag, "_zero"}, 64'(zero),     64'(INIT == 4'd0));
    endtask

    initial begin
        logic [2*CBITS+1:0] got;
        logic [CBITS-1:0]   gseq[20];
        int                 wraps;
        logic               prev_wrap;

        rst_n = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
`ifdef GRAY_MOD_EN
        mod_max = MOD;
`endif
        m_cnt = INIT; m_wrap = 1'b0;
        #7;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef GRAY_MOD_EN
        // 20 up steps: 1..15,0..4 with a single wrap at 15->0
        wraps = 0;
        for (int i = 0; i < 20; i++) begin
            drive_step(1'b1, 1'b0, 1'b0, 1'b0, '0, got);
            gseq[i] = got[CBITS+1:2];
            if (got[1]) wraps++;
            if (i == 15) check("wrap_15_to_0", 64'(got[1]), 64'd1);
        end
        check("gray_s1", 64'(gseq[0]), 64'd1);
        check("gray_s2", 64'(gseq[1]), 64'd3);
        check("gray_s3", 64'(gseq[2]), 64'd2);
        check("gray_s4", 64'(gseq[3]), 64'd6);
        check("wrap_count_20", 64'(wraps), 64'd1);
        check("bin_after_20", 64'(bin_cnt), 64'd4);

        // down from 0
        drive_step(1'b0, 1'b0, 1'b1, 1'b0, '0, got);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0, '0, got);
        check("down_bin", 64'(bin_cnt), 64'd15);
        check("down_gray", 64'(gray_cnt), 64'd8);
        check("down_wrap", 64'(wrap), 64'd1);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0, '0, got);
        check("down2_bin", 64'(bin_cnt), 64'd14);
        check("down2_wrap", 64'(wrap), 64'd0);

        // up to all-ones then step down: no wrap
        drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, got);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0, '0, got);
        check("ones_down_wrap", 64'(wrap), 64'd0);
`else
        // modulus 9: 0..9,0 with wrap on 9->0
        for (int i = 0; i < 10; i++) begin
            drive_step(1'b1, 1'b0, 1'b0, 1'b0, '0, got);
            if (i == 9) begin
                check("mod_wrap", 64'(got[1]), 64'd1);
                check("mod_bin0", 64'(bin_cnt), 64'd0);
            end
        end
        drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, got);
        drive_step(1'b1, 1'b0, 1'b0, 1'b0, '0, got);
        check("mod_over_bin", 64'(bin_cnt), 64'd0);
        check("mod_over_wrap", 64'(wrap), 64'd1);
        drive_step(1'b1, 1'b1, 1'b0, 1'b0, '0, got);
        check("mod_down_bin", 64'(bin_cnt), 64'd9);
        check("mod_down_wrap", 64'(wrap), 64'd1);
`endif

        // clr beats load beats en
        drive_step(1'b1, 1'b0, 1'b1, 1'b1, 4'd9, got);
        check("prio_bin", 64'(bin_cnt), 64'(INIT));
        check("prio_wrap", 64'(wrap), 64'd0);
        drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, got);
        check("load_bin", 64'(bin_cnt), 64'd9);
        check("load_gray", 64'(gray_cnt), 64'd13);

        // asynchronous reset between edges at count 7
        drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, got);
        check("pre_rst_bin", 64'(bin_cnt), 64'd7);
        en = 1'b1; load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        en = 1'b0; dir = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        m_cnt = INIT; m_wrap = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // random phase
        for (int i = 0; i < 1000; i++) begin
            drive_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                       1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), got);
        end

        // liveness: steady up count
        wraps = 0;
        prev_wrap = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive_step(1'b1, 1'b0, 1'b0, 1'b0, '0, got);
            if (prev_wrap) check("wrap_then_low", 64'(got[1]), 64'd0);
            if (got[1]) wraps++;
            prev_wrap = got[1];
        end
        check("wrap_pulses_ge12", 64'(wraps >= 12), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
